// File: rtl/mcu_target_arb.sv
// mcu_target_arb: routes MCU byte transfers to one of four targets, a local
// control register (interrupt mask) or a sink. The first byte of each transfer
// selects the destination. Replies are muxed back to the MCU, and the masked
// target interrupts drive an active-low interrupt line. A transfer that stays
// quiet for too long is dropped back to idle.
module mcu_target_arb #(
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in_strobe,
  input  logic        data_in_start,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [3:0]  tgt_strobe,
  output logic        tgt_start,
  output logic [7:0]  tgt_data,
  input  logic [31:0] tgt_dout,
  input  logic [3:0]  tgt_irq,
  output logic        int_out_n,
  output logic [2:0]  sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_CTRL,
    S_DROP
  } state_t;

  state_t      state;
  logic [1:0]  target;
  logic        first_byte;
  logic [3:0]  irq_mask;
  logic [31:0] idle_cnt;

  // Transfer FSM, target forwarding, reply mux, interrupt line and idle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      target     <= 2'd0;
      first_byte <= 1'b0;
      irq_mask   <= 4'hF;
      idle_cnt   <= 32'd0;
      tgt_strobe <= 4'b0000;
      tgt_start  <= 1'b0;
      tgt_data   <= 8'h00;
      data_out   <= 8'hFF;
      int_out_n  <= 1'b1;
    end else begin
      tgt_strobe <= 4'b0000;

      case (state)
        S_FWD:   data_out <= tgt_dout[{target, 3'b000} +: 8];
        S_CTRL:  data_out <= {4'h0, tgt_irq & irq_mask};
        default: data_out <= 8'hFF;
      endcase

      int_out_n <= ~|(tgt_irq & irq_mask);

      if (data_in_strobe) begin
        idle_cnt <= 32'd0;
        if (data_in_start) begin
          first_byte <= 1'b1;
          if (data_in[7:2] == 6'd0) begin
            state  <= S_FWD;
            target <= data_in[1:0];
          end else if (data_in == 8'h0F) begin
            state <= S_CTRL;
          end else begin
            state <= S_DROP;
          end
        end else begin
          case (state)
            S_FWD: begin
              tgt_strobe <= 4'b0001 << target;
              tgt_data   <= data_in;
              tgt_start  <= first_byte;
              first_byte <= 1'b0;
            end
            S_CTRL: begin
              if (first_byte) begin
                irq_mask <= data_in[3:0];
              end
              first_byte <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end else if (state == S_IDLE) begin
        idle_cnt <= 32'd0;
      end else if (idle_cnt >= TIMEOUT - 32'd1) begin
        state      <= S_IDLE;
        first_byte <= 1'b0;
        idle_cnt   <= 32'd0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end

  // Debug view of the state: 1tt = forwarding to target tt, 001 = control, 010 = drop.
  always_comb begin
    sel = 3'b000;
    case (state)
      S_FWD:   sel = {1'b1, target};
      S_CTRL:  sel = 3'b001;
      S_DROP:  sel = 3'b010;
      default: sel = 3'b000;
    endcase
  end

endmodule
